// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: divides clk down to the pixel rate and emits
// coordinates, sync pulses, active-video flag and line/frame strobes.
module vga_sync_gen #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int CLK_DIV     = 2,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       line_tick,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic       SYNC_ON  = (SYNC_ACTIVE != 0);

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       h_q, h_d;
  logic [9:0]       v_q, v_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             line_tick_q, line_tick_d;
  logic             frame_tick_q, frame_tick_d;

  // With CLK_DIV=1 the divider never leaves 0, so p_tick is constantly high.
  assign p_tick = (div_q == DIV_LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    div_d = div_q;
    h_d   = h_q;
    v_d   = v_q;
    if (reset) begin
      div_d = '0;
      h_d   = '0;
      v_d   = '0;
    end else if (p_tick) begin
      div_d = '0;
      h_d   = (h_q == H_LAST) ? '0 : h_q + 10'd1;
      if (h_q == H_LAST) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end

    // Decoded from next-state so these flops switch on the same edge as the coordinates.
    hsync_d      = (h_d >= HS_FIRST && h_d <= HS_LAST) ? SYNC_ON : ~SYNC_ON;
    vsync_d      = (v_d >= VS_FIRST && v_d <= VS_LAST) ? SYNC_ON : ~SYNC_ON;
    video_on_d   = (h_d < H_VIS) && (v_d < V_VIS);
    line_tick_d  = (div_d == '0) && (h_d == '0) && !reset;
    frame_tick_d = line_tick_d && (v_d == '0);
  end

  // NOTE: reset is folded into the _d logic above, so this block is a plain register bank.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    div_q        <= div_d;
    h_q          <= h_d;
    v_q          <= v_d;
    hsync_q      <= hsync_d;
    vsync_q      <= vsync_d;
    video_on_q   <= video_on_d;
    line_tick_q  <= line_tick_d;
    frame_tick_q <= frame_tick_d;
  end

  assign pix_x      = h_q;
  assign pix_y      = v_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign video_on   = video_on_q;
  assign line_tick  = line_tick_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench: five generator instances (defaults, active-high sync,
// CLK_DIV=1, and two shrunk rasters) compared every clk against an arithmetic model.
module tb_vga_sync_gen;

  localparam int N = 5;
  localparam int HD[N] = '{640, 640, 640, 8, 8};
  localparam int HF[N] = '{16, 16, 16, 2, 2};
  localparam int HS[N] = '{96, 96, 96, 3, 3};
  localparam int HB[N] = '{48, 48, 48, 2, 2};
  localparam int VD[N] = '{480, 480, 480, 6, 6};
  localparam int VF[N] = '{10, 10, 10, 1, 1};
  localparam int VS[N] = '{2, 2, 2, 2, 2};
  localparam int VB[N] = '{33, 33, 33, 1, 1};
  localparam int CD[N] = '{2, 2, 1, 3, 1};
  localparam int SA[N] = '{0, 1, 0, 0, 0};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic       pt[N];
  logic [9:0] px[N];
  logic [9:0] py[N];
  logic       hs[N];
  logic       vs[N];
  logic       vo[N];
  logic       lt[N];
  logic       ft[N];

  int total = 0;
  int bad   = 0;
  int n     = 0;   // clk edges since the last edge that saw reset=1

  always #5 clk = ~clk;

  vga_sync_gen u0 (.clk(clk), .reset(reset), .p_tick(pt[0]), .pix_x(px[0]), .pix_y(py[0]),
    .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]), .line_tick(lt[0]), .frame_tick(ft[0]));

  vga_sync_gen #(.SYNC_ACTIVE(1)) u1 (.clk(clk), .reset(reset), .p_tick(pt[1]), .pix_x(px[1]),
    .pix_y(py[1]), .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]), .line_tick(lt[1]),
    .frame_tick(ft[1]));

  vga_sync_gen #(.CLK_DIV(1)) u2 (.clk(clk), .reset(reset), .p_tick(pt[2]), .pix_x(px[2]),
    .pix_y(py[2]), .hsync(hs[2]), .vsync(vs[2]), .video_on(vo[2]), .line_tick(lt[2]),
    .frame_tick(ft[2]));

  vga_sync_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_DISPLAY(6),
    .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(3)) u3 (.clk(clk), .reset(reset),
    .p_tick(pt[3]), .pix_x(px[3]), .pix_y(py[3]), .hsync(hs[3]), .vsync(vs[3]),
    .video_on(vo[3]), .line_tick(lt[3]), .frame_tick(ft[3]));

  vga_sync_gen #(.H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2), .V_DISPLAY(6),
    .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .CLK_DIV(1)) u4 (.clk(clk), .reset(reset),
    .p_tick(pt[4]), .pix_x(px[4]), .pix_y(py[4]), .hsync(hs[4]), .vsync(vs[4]),
    .video_on(vo[4]), .line_tick(lt[4]), .frame_tick(ft[4]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] got_vec(input int i);
    return {pt[i], px[i], py[i], hs[i], vs[i], vo[i], lt[i], ft[i]};
  endfunction

  // Raster position follows directly from the edge count: pixel = n / CLK_DIV.
  function automatic logic [25:0] exp_vec(input int i, input int cnt);
    int ht, vt, p, d, x, y;
    logic e_pt, e_hs, e_vs, e_vo, e_lt, e_ft, act;
    ht   = HD[i] + HF[i] + HS[i] + HB[i];
    vt   = VD[i] + VF[i] + VS[i] + VB[i];
    p    = cnt / CD[i];
    d    = cnt % CD[i];
    x    = p % ht;
    y    = (p / ht) % vt;
    act  = (SA[i] != 0);
    e_pt = (d == CD[i] - 1);
    e_hs = (x >= HD[i] + HF[i] && x < HD[i] + HF[i] + HS[i]) ? act : !act;
    e_vs = (y >= VD[i] + VF[i] && y < VD[i] + VF[i] + VS[i]) ? act : !act;
    e_vo = (x < HD[i]) && (y < VD[i]);
    e_lt = (cnt > 0) && (d == 0) && (x == 0);
    e_ft = e_lt && (y == 0);
    return {e_pt, 10'(x), 10'(y), e_hs, e_vs, e_vo, e_lt, e_ft};
  endfunction

  task automatic step();
    @(posedge clk);
    if (reset) n = 0;
    else n++;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d_n%0d", i, n), 32'(got_vec(i)), 32'(exp_vec(i, n)));
    end
  endtask

  initial begin
    int hs0_low, hs0_min, hs0_max, vo0_low, lt0_cnt, hs1_high, hs2_low;
    int f3a, f3b, f4a, f4b, waited;
    bit found;
    hs0_low = 0; hs0_min = 1023; hs0_max = 0; vo0_low = 0; lt0_cnt = 0;
    hs1_high = 0; hs2_low = 0; f3a = 0; f3b = 0; f4a = 0; f4b = 0;

    reset = 1'b1;
    for (int k = 0; k < 3; k++) step();
    check("rst_px", 32'(px[0]), 32'd0);
    check("rst_py", 32'(py[0]), 32'd0);
    check("rst_hs", 32'(hs[0]), 32'd1);
    check("rst_vs", 32'(vs[0]), 32'd1);
    check("rst_vo", 32'(vo[0]), 32'd1);
    check("rst_ticks", 32'({lt[0], ft[0]}), 32'd0);
    check("rst_ptick", 32'(pt[0]), 32'd0);
    check("rst_hs_hi", 32'(hs[1]), 32'd0);
    check("rst_ptick_div1", 32'(pt[2]), 32'd1);

    reset = 1'b0;
    for (int k = 0; k < 1800; k++) begin
      step();
      if (n <= 1600) begin
        if (!hs[0]) begin
          hs0_low++;
          if (int'(px[0]) < hs0_min) hs0_min = int'(px[0]);
          if (int'(px[0]) > hs0_max) hs0_max = int'(px[0]);
        end
        if (!vo[0]) vo0_low++;
        if (lt[0]) lt0_cnt++;
        if (hs[1]) hs1_high++;
      end
      if (n <= 800 && !hs[2]) hs2_low++;
      if (n == 2) check("px_adv", 32'(px[0]), 32'd1);
      if (n == 1599) check("pre_wrap", 32'({px[0], py[0]}), 32'({10'd799, 10'd0}));
      if (n == 1600) check("wrap", 32'({px[0], py[0], lt[0]}), 32'({10'd0, 10'd1, 1'b1}));
      if (ft[3]) begin
        if (f3a == 0) f3a = n;
        else if (f3b == 0) f3b = n;
      end
      if (ft[4]) begin
        if (f4a == 0) f4a = n;
        else if (f4b == 0) f4b = n;
      end
    end
    check("hs_low_clks", 32'(hs0_low), 32'd192);
    check("hs_first_x", 32'(hs0_min), 32'd656);
    check("hs_last_x", 32'(hs0_max), 32'd751);
    check("vo_low_clks", 32'(vo0_low), 32'd320);
    check("line_ticks", 32'(lt0_cnt), 32'd1);
    check("hs_high_clks_sa1", 32'(hs1_high), 32'd192);
    check("hs_low_clks_div1", 32'(hs2_low), 32'd96);
    check("frame1_div3", 32'(f3a), 32'd450);
    check("frame2_div3", 32'(f3b), 32'd900);
    check("frame1_div1", 32'(f4a), 32'd150);
    check("frame2_div1", 32'(f4b), 32'd300);

    // Reset while the shrunk raster sits inside both sync pulses.
    found = 1'b0;
    waited = 0;
    while (!found && waited < 2000) begin
      step();
      waited++;
      if (!hs[3] && !vs[3]) found = 1'b1;
    end
    check("sync_wait", 32'(found), 32'd1);
    reset = 1'b1;
    step();
    check("syncrst_hs_vs", 32'({hs[3], vs[3]}), 32'd3);
    check("syncrst_xy", 32'({px[3], py[3]}), 32'd0);
    reset = 1'b0;

    // Random run lengths and reset pulses landing at arbitrary divider phases.
    for (int r = 0; r < 20; r++) begin
      int run_len, hold;
      run_len = $urandom_range(600, 1);
      hold    = $urandom_range(4, 1);
      for (int k = 0; k < run_len; k++) step();
      reset = 1'b1;
      for (int k = 0; k < hold; k++) step();
      reset = 1'b0;
    end
    for (int k = 0; k < 200; k++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
